axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit (used only under AXIL_MASTER_TIMEOUT_EN).
REQ-004 SHALL have ports, one clock and synchronous active-high reset:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready: standard AXI4-Lite master-side signals, widths per ADDR_WIDTH/DATA_WIDTH, driving the axi4_lite slave port of axi4_lite_mem.

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
REQ-006 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready captures cmd_* into registers; IDLE->WRITE if cmd_write else RADDR.
REQ-007 SHALL, in WRITE, drive awvalid and wvalid together on the cycle after capture; each deasserts independently on its own handshake (aw_done/w_done flags); both done -> WRESP.
REQ-008 SHALL accept AW and W handshakes in either order or the same cycle; awaddr/wdata/wstrb stable while the corresponding valid is high.
REQ-009 SHALL assert bready in WRESP; bvalid&bready latches bresp into rsp_resp, rsp_write=1, rsp_rdata=0 -> RSP.
REQ-010 SHALL assert arvalid in RADDR until arready; -> RDATA.
REQ-011 SHALL assert rready in RDATA; rvalid&rready latches rdata/rresp, rsp_write=0 -> RSP.
REQ-012 SHALL hold rsp_valid and all rsp_* stable in RSP until rsp_ready; rsp_valid&rsp_ready -> IDLE.
REQ-013 SHALL have one outstanding transaction; minimum latency with zero-wait slave and rsp_ready high: capture to rsp_valid 3 cycles, command-to-command 4 cycles.
REQ-014 SHALL never assert a valid combinationally from a ready; all AXI outputs registered.
REQ-015 SHALL drive awaddr/araddr/wdata/wstrb to 0 when the corresponding valid is low.

Reset
REQ-016 SHALL on rst: state=IDLE, cmd_ready=0 during reset, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0, all AXI valids/readies 0, addresses/data/strobes 0, done flags cleared.
REQ-017 SHALL treat rst mid-transaction as abort: outputs take reset values next edge, in-flight command discarded, no response issued.
REQ-018 SHALL assert cmd_ready on the first cycle after rst deasserts.

Configuration
REQ-019 SHALL compile in watchdog when AXIL_MASTER_TIMEOUT_EN is defined: counter clears on entering WRITE/WRESP/RADDR/RDATA and on any AXI handshake; reaching TIMEOUT_CYCLES in those states drops all AXI valids/readies, sets rsp_resp=2'b10, rsp_rdata=0, goes to RSP.
REQ-020 SHALL, without AXIL_MASTER_TIMEOUT_EN, contain no counter and wait indefinitely.

Verification
REQ-021 Write addr 0x1 data 0xAAAAAAAA wstrb 0xF, zero-wait slave -> awvalid&wvalid one cycle, rsp_valid 3 cycles after capture, rsp_write=1, rsp_resp=0.
REQ-022 Read addr 0x1 after REQ-021 -> rsp_rdata=0xAAAAAAAA, rsp_write=0, rsp_resp=0.
REQ-023 Slave delays wready 3 cycles after awready -> awvalid drops after 1 cycle, wvalid held 4 cycles, single B handshake, rsp_resp=0.
REQ-024 Back-to-back writes 0x1/0x2/0x3 (0xAAAAAAAA, 0x55555555, 0xF0F0F0F0), rsp_ready low 2 cycles each -> rsp_* stable while held, reads return same data in order.
REQ-025 Assert rst while in RDATA -> next edge all valids 0, rsp_valid 0, no response; cmd_ready=1 cycle after release.
REQ-026 With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready tied 0 -> after 16 cycles arvalid=0, rsp_valid=1, rsp_resp=2'b10, rsp_rdata=0.

Source files
------------

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite channel bundle shared by a master and a slave.
// The master modport drives addresses, data, valids and bready/rready.
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into an AXI
// read or write and returns the result on rsp_*. Define AXIL_MASTER_TIMEOUT_EN
// to compile in a watchdog that ends a stalled transfer with rsp_resp=2'b10.
module axi4_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4_lite_master_if.master      axi
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  state_t state, next_state;
  logic   aw_done, w_done;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic   timeout;

  // Held low through reset so no command can be captured while aborting.
  assign cmd_ready = (state == IDLE) && !rst;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid  && axi.wready;
  assign b_hs  = axi.bvalid  && axi.bready;
  assign ar_hs = axi.arvalid && axi.arready;
  assign r_hs  = axi.rvalid  && axi.rready;

  // NOTE: registers are updated only with non-blocking (<=) assignments so every
  // flop samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets its default before the case, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cmd_valid && cmd_ready) next_state = cmd_write ? WRITE : RADDR;
      WRITE: begin
        if (timeout)                                        next_state = RSP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))    next_state = WRESP;
      end
      WRESP: if (timeout || b_hs) next_state = RSP;
      RADDR: begin
        if (timeout)    next_state = RSP;
        else if (ar_hs) next_state = RDATA;
      end
      RDATA: if (timeout || r_hs) next_state = RSP;
      RSP:   if (rsp_ready)       next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             in_axi;
  logic             any_hs;

  assign in_axi  = (state == WRITE) || (state == WRESP) || (state == RADDR) || (state == RDATA);
  assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
  assign timeout = in_axi && !any_hs && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles of the current bus phase; any progress restarts it.
  always_ff @(posedge clk) begin
    if (rst || !in_axi || any_hs || (next_state != state)) wd_cnt <= '0;
    else                                                   wd_cnt <= wd_cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Every AXI output is a flop: valids rise on capture and fall only on their own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
    end else if (timeout) begin
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_write   <= (state == WRITE) || (state == WRESP);
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b10;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              axi.awvalid <= 1'b1;
              axi.awaddr  <= cmd_addr;
              axi.wvalid  <= 1'b1;
              axi.wdata   <= cmd_wdata;
              axi.wstrb   <= cmd_wstrb;
            end else begin
              axi.arvalid <= 1'b1;
              axi.araddr  <= cmd_addr;
            end
          end
        end
        WRITE: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            axi.wdata  <= '0;
            axi.wstrb  <= '0;
            w_done     <= 1'b1;
          end
          if (next_state == WRESP) axi.bready <= 1'b1;
        end
        WRESP: begin
          if (b_hs) begin
            axi.bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= axi.bresp;
          end
        end
        RADDR: begin
          if (ar_hs) begin
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (r_hs) begin
            axi.rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b0;
            rsp_rdata  <= axi.rdata;
            rsp_resp   <= axi.rresp;
          end
        end
        RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: a small memory slave, a response model
// built from plain memory semantics, and a per-cycle compare process.
module tb_axi4_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  always #5 clk = ~clk;

  axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (axi)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory slave ----------------
  int          w_delay   = 0;
  bit          ar_en     = 1'b1;
  bit          r_hold    = 1'b0;
  int          w_wait;
  logic [31:0] smem [16];
  logic        got_aw, got_w;
  logic [31:0] s_aw_addr, s_w_data;
  logic [3:0]  s_w_strb;
  logic        aw_now, w_now;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign axi.awready = 1'b1;
  assign axi.wready  = (w_wait >= w_delay);
  assign axi.arready = ar_en;
  assign axi.bresp   = 2'b00;
  assign axi.rresp   = 2'b00;
  assign aw_now  = axi.awvalid && axi.awready;
  assign w_now   = axi.wvalid && axi.wready;
  assign wr_addr = aw_now ? axi.awaddr : s_aw_addr;
  assign wr_data = w_now ? axi.wdata : s_w_data;
  assign wr_strb = w_now ? axi.wstrb : s_w_strb;

  always @(posedge clk) begin
    if (rst) begin
      w_wait     <= 0;
      got_aw     <= 1'b0;
      got_w      <= 1'b0;
      s_aw_addr  <= '0;
      s_w_data   <= '0;
      s_w_strb   <= '0;
      axi.bvalid <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
    end else begin
      if (w_now)           w_wait <= 0;
      else if (axi.wvalid) w_wait <= w_wait + 1;
      if ((got_aw || aw_now) && (got_w || w_now)) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) smem[wr_addr[3:0]][8*b +: 8] <= wr_data[8*b +: 8];
        axi.bvalid <= 1'b1;
        got_aw     <= 1'b0;
        got_w      <= 1'b0;
      end else begin
        if (aw_now) begin got_aw <= 1'b1; s_aw_addr <= axi.awaddr; end
        if (w_now)  begin got_w <= 1'b1; s_w_data <= axi.wdata; s_w_strb <= axi.wstrb; end
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.arvalid && axi.arready && !r_hold) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= smem[axi.araddr[3:0]];
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  // ---------------- response model ----------------
  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t        exp_q [$];
  rsp_t        got_q [$];
  logic [31:0] ref_mem [16];
  int          cap_q [$];
  int          rise_q [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // rsp_ready driver: always ready, or held low for the first two cycles of each response
  bit hold_mode = 1'b0;
  initial begin
    int held;
    held      = 0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      held      = rsp_valid ? held + 1 : 0;
      rsp_ready = !hold_mode || (held > 2);
    end
  end

  // ---------------- compare process ----------------
  int          aw_hi, w_hi, ar_hi, b_hs_cnt, stall_cnt;
  bit          allow_drop = 1'b0;
  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready, p_rsp_valid;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    if (!rst) begin
      if (!axi.awvalid) check("awaddr_zero_idle", axi.awaddr, 0);
      if (!axi.wvalid) begin
        check("wdata_zero_idle", axi.wdata, 0);
        check("wstrb_zero_idle", axi.wstrb, 0);
      end
      if (!axi.arvalid) check("araddr_zero_idle", axi.araddr, 0);
      if (p_awvalid && !p_awready) begin
        check("aw_valid_held", axi.awvalid, 1'b1);
        check("aw_addr_stable", axi.awaddr, p_awaddr);
      end
      if (p_wvalid && !p_wready) begin
        check("w_valid_held", axi.wvalid, 1'b1);
        check("w_data_stable", axi.wdata, p_wdata);
        check("w_strb_stable", axi.wstrb, p_wstrb);
      end
      if (p_arvalid && !p_arready && !allow_drop) begin
        check("ar_valid_held", axi.arvalid, 1'b1);
        check("ar_addr_stable", axi.araddr, p_araddr);
      end
      if (axi.awvalid) aw_hi <= aw_hi + 1;
      if (axi.wvalid)  w_hi  <= w_hi + 1;
      if (axi.arvalid) ar_hi <= ar_hi + 1;
      if (axi.bvalid && axi.bready) b_hs_cnt <= b_hs_cnt + 1;
      if (rsp_valid && !p_rsp_valid) rise_q.push_back(cyc);
      if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          check("rsp_write", rsp_write, exp_q[0].is_write);
          check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          check("rsp_resp", rsp_resp, exp_q[0].resp);
          if (rsp_ready) begin
            got_q.push_back('{is_write: rsp_write, rdata: rsp_rdata, resp: rsp_resp});
            void'(exp_q.pop_front());
          end
        end
      end
    end
    p_awvalid   <= axi.awvalid;
    p_awready   <= axi.awready;
    p_awaddr    <= axi.awaddr;
    p_wvalid    <= axi.wvalid;
    p_wready    <= axi.wready;
    p_wdata     <= axi.wdata;
    p_wstrb     <= axi.wstrb;
    p_arvalid   <= axi.arvalid;
    p_arready   <= axi.arready;
    p_araddr    <= axi.araddr;
    p_rsp_valid <= rsp_valid;
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit expect_timeout);
    rsp_t e;
    int   n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wr ? d : 32'h0;
    cmd_wstrb = wr ? s : 4'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    check("cmd_accept", cmd_ready, 1'b1);
    if (cmd_ready) begin
      cap_q.push_back(cyc);
      e.is_write = wr;
      e.resp     = 2'b00;
      e.rdata    = 32'h0;
      if (expect_timeout) begin
        e.resp = 2'b10;
      end else if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a[3:0]][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rdata = ref_mem[a[3:0]];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    cap_q.delete();
    rise_q.delete();
    got_q.delete();
    aw_hi     = 0;
    w_hi      = 0;
    ar_hi     = 0;
    b_hs_cnt  = 0;
    stall_cnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int seen;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    clear_stats();

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_write", rsp_write, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check("rst_readies", {axi.bready, axi.rready}, 0);
    check("rst_addr_data", {axi.awaddr, axi.araddr, axi.wdata}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // zero-wait write then read-back, back to back
    clear_stats();
    send(1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF, 1'b0);
    send(1'b0, 32'h1, 32'h0, 4'h0, 1'b0);
    wait_idle();
    check("t1_rsp_count", rise_q.size(), 2);
    check("t1_wr_latency", rise_q[0] - cap_q[0], 3);
    check("t1_rd_latency", rise_q[1] - cap_q[1], 3);
    check("t1_cmd_to_cmd", cap_q[1] - cap_q[0], 4);
    check("t1_aw_cycles", aw_hi, 1);
    check("t1_w_cycles", w_hi, 1);
    check("t1_wr_is_write", got_q[0].is_write, 1'b1);
    check("t1_wr_resp", got_q[0].resp, 2'b00);
    check("t1_rd_is_write", got_q[1].is_write, 1'b0);
    check("t1_rd_data", got_q[1].rdata, 32'hAAAA_AAAA);
    check("t1_rd_resp", got_q[1].resp, 2'b00);

    // W channel stalled three cycles behind AW
    clear_stats();
    w_delay = 3;
    send(1'b1, 32'h4, 32'h1234_5678, 4'hF, 1'b0);
    wait_idle();
    w_delay = 0;
    check("t2_aw_cycles", aw_hi, 1);
    check("t2_w_cycles", w_hi, 4);
    check("t2_b_handshakes", b_hs_cnt, 1);
    check("t2_latency", rise_q[0] - cap_q[0], 6);
    check("t2_resp", got_q[0].resp, 2'b00);

    // three writes then three reads with rsp_ready held off two cycles each
    clear_stats();
    hold_mode = 1'b1;
    send(1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF, 1'b0);
    send(1'b1, 32'h2, 32'h5555_5555, 4'hF, 1'b0);
    send(1'b1, 32'h3, 32'hF0F0_F0F0, 4'hF, 1'b0);
    send(1'b0, 32'h1, 32'h0, 4'h0, 1'b0);
    send(1'b0, 32'h2, 32'h0, 4'h0, 1'b0);
    send(1'b0, 32'h3, 32'h0, 4'h0, 1'b0);
    wait_idle();
    hold_mode = 1'b0;
    check("t3_rsp_count", got_q.size(), 6);
    check("t3_stall_cycles", stall_cnt, 12);
    check("t3_rd1", got_q[3].rdata, 32'hAAAA_AAAA);
    check("t3_rd2", got_q[4].rdata, 32'h5555_5555);
    check("t3_rd3", got_q[5].rdata, 32'hF0F0_F0F0);

    // single-byte strobe merges into an existing word
    clear_stats();
    send(1'b1, 32'h2, 32'h0000_00AB, 4'h1, 1'b0);
    send(1'b0, 32'h2, 32'h0, 4'h0, 1'b0);
    wait_idle();
    check("t4_strobe_merge", got_q[1].rdata, 32'h5555_55AB);

    // reset while waiting for read data
    clear_stats();
    r_hold = 1'b1;
    send(1'b0, 32'h3, 32'h0, 4'h0, 1'b0);
    seen = 0;
    while (!axi.rready && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("t5_in_rdata", axi.rready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t5_valids_cleared", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check("t5_readies_cleared", {axi.bready, axi.rready}, 0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_cmd_ready_in_rst", cmd_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    r_hold = 1'b0;
    @(negedge clk);
    check("t5_cmd_ready_after", cmd_ready, 1'b1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_response", seen, 0);
    @(posedge clk);
    #1;
    clear_stats();
    send(1'b0, 32'h3, 32'h0, 4'h0, 1'b0);
    wait_idle();
    check("t5_recover_read", got_q[0].rdata, 32'hF0F0_F0F0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // arready never rises: watchdog ends the read after 16 cycles of arvalid
    clear_stats();
    ar_en      = 1'b0;
    allow_drop = 1'b1;
    send(1'b0, 32'h1, 32'h0, 4'h0, 1'b1);
    wait_idle();
    ar_en      = 1'b1;
    allow_drop = 1'b0;
    check("t6_ar_cycles", ar_hi, 16);
    check("t6_latency", rise_q[0] - cap_q[0], 17);
    check("t6_resp", got_q[0].resp, 2'b10);
    check("t6_rdata", got_q[0].rdata, 0);
    check("t6_is_write", got_q[0].is_write, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
